// File: rtl/regfile_sb.sv
// regfile_sb: multi-port register file with write-through bypass and write-pending scoreboard
module regfile_sb #(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 5,
  parameter int                NUM_RD   = 2,
  parameter int                NUM_WR   = 2,
  parameter int                SP_INDEX = 29,
  parameter logic [DATA_W-1:0] SP_INIT  = 32'h000007fc,
  parameter bit                READ_REG = 1'b0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr
);
  localparam int DEPTH = 1 << ADDR_W;
  logic [DATA_W-1:0]        regs [DEPTH];
  logic [DEPTH-1:0]         busy;
  logic [NUM_RD*DATA_W-1:0] rd_val;
  function automatic logic wr_hit(input logic [ADDR_W-1:0] a);
    wr_hit = 1'b0;
    for (int j = 0; j < NUM_WR; j++)
      if (wr_en[j] && wr_addr[j*ADDR_W +: ADDR_W] == a) wr_hit = 1'b1;
  endfunction
  // Register storage; later write ports override earlier ones on address collision
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int a = 0; a < DEPTH; a++) regs[a] <= (a == SP_INDEX) ? SP_INIT : '0;
    end else begin
      for (int j = 0; j < NUM_WR; j++)
        if (wr_en[j] && wr_addr[j*ADDR_W +: ADDR_W] != '0)
          regs[wr_addr[j*ADDR_W +: ADDR_W]] <= wr_data[j*DATA_W +: DATA_W];
    end
  end
  // Scoreboard: issue sets busy and beats a same-cycle writeback, writeback clears it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy <= '0;
    end else begin
      for (int a = 1; a < DEPTH; a++)
        if (iss_en && iss_addr == ADDR_W'(a)) busy[a] <= 1'b1;
        else if (wr_hit(ADDR_W'(a))) busy[a] <= 1'b0;
    end
  end
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              hit;
    logic [DATA_W-1:0] byp;
    assign ra = rd_addr[i*ADDR_W +: ADDR_W];
    // Bypass from the highest-index write port matching this read address
    always_comb begin
      hit = 1'b0;
      byp = '0;
      for (int j = 0; j < NUM_WR; j++)
        if (wr_en[j] && wr_addr[j*ADDR_W +: ADDR_W] == ra) begin
          hit = 1'b1;
          byp = wr_data[j*DATA_W +: DATA_W];
        end
    end
    assign rd_busy[i]                 = busy[ra] & ~hit;
    assign rd_val[i*DATA_W +: DATA_W] = (ra == '0) ? '0 : hit ? byp : regs[ra];
  end
  if (READ_REG) begin : g_reg
    logic [NUM_RD*DATA_W-1:0] rd_q;
    // One-cycle registered read of the bypassed value
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) rd_q <= '0;
      else rd_q <= rd_val;
    end
    assign rd_data = rd_q;
  end else begin : g_comb
    assign rd_data = rd_val;
  end
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed checks of combinational and registered-read register files
module tb_regfile_sb;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [9:0]  rd_addr = '0;
  logic [1:0]  wr_en = '0;
  logic [9:0]  wr_addr = '0;
  logic [63:0] wr_data = '0;
  logic        iss_en = 1'b0;
  logic [4:0]  iss_addr = '0;
  logic [63:0] c_data, r_data;
  logic [1:0]  c_busy, r_busy;
  int vectors = 0;
  int miscompares = 0;
  always #5 clk = ~clk;
  regfile_sb #(.READ_REG(1'b0)) u_comb (
    .clk(clk), .reset_n(reset_n), .rd_addr(rd_addr), .rd_data(c_data), .rd_busy(c_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en), .iss_addr(iss_addr)
  );
  regfile_sb #(.READ_REG(1'b1)) u_reg (
    .clk(clk), .reset_n(reset_n), .rd_addr(rd_addr), .rd_data(r_data), .rd_busy(r_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en), .iss_addr(iss_addr)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step(input logic [4:0] r0, input logic [4:0] r1, input logic [1:0] we,
                      input logic [4:0] a0, input logic [31:0] d0,
                      input logic [4:0] a1, input logic [31:0] d1,
                      input logic ie, input logic [4:0] ia);
    @(negedge clk);
    rd_addr  = {r1, r0};
    wr_en    = we;
    wr_addr  = {a1, a0};
    wr_data  = {d1, d0};
    iss_en   = ie;
    iss_addr = ia;
    #1;
  endtask
  initial begin
    step(0, 0, 2'b00, 0, 0, 0, 0, 1'b0, 0);
    chk("reset_reg_data", r_data[31:0], 32'h0);
    chk("reset_busy", {30'd0, c_busy}, 32'h0);
    step(29, 0, 2'b00, 0, 0, 0, 0, 1'b0, 0);
    chk("reset_sp", c_data[31:0], 32'h000007fc);
    reset_n = 1'b1;
    step(5, 0, 2'b01, 5, 32'hDEADBEEF, 0, 0, 1'b0, 0);
    chk("bypass_p0", c_data[31:0], 32'hDEADBEEF);
    chk("bypass_p1_zero", c_data[63:32], 32'h0);
    step(5, 0, 2'b00, 0, 0, 0, 0, 1'b0, 0);
    chk("stored_r5", c_data[31:0], 32'hDEADBEEF);
    chk("reg_r5_latency", r_data[31:0], 32'hDEADBEEF);
    step(7, 7, 2'b11, 7, 32'h11, 7, 32'h22, 1'b0, 0);
    chk("collide_byp_p0", c_data[31:0], 32'h22);
    chk("collide_byp_p1", c_data[63:32], 32'h22);
    step(7, 0, 2'b00, 0, 0, 0, 0, 1'b0, 0);
    chk("collide_stored", c_data[31:0], 32'h22);
    chk("collide_reg", r_data[31:0], 32'h22);
    step(0, 0, 2'b01, 0, 32'hFFFFFFFF, 0, 0, 1'b1, 0);
    chk("zero_byp", c_data[31:0], 32'h0);
    chk("zero_busy_now", {31'd0, c_busy[0]}, 32'h0);
    step(0, 0, 2'b00, 0, 0, 0, 0, 1'b0, 0);
    chk("zero_after", c_data[31:0], 32'h0);
    chk("zero_busy_after", {31'd0, c_busy[0]}, 32'h0);
    chk("zero_reg", r_data[31:0], 32'h0);
    step(3, 0, 2'b00, 0, 0, 0, 0, 1'b1, 3);
    chk("issue_same_cycle", {31'd0, c_busy[0]}, 32'h0);
    step(3, 3, 2'b00, 0, 0, 0, 0, 1'b0, 0);
    chk("busy_p0", {31'd0, c_busy[0]}, 32'h1);
    chk("busy_p1", {31'd0, c_busy[1]}, 32'h1);
    chk("busy_reg_ver", {31'd0, r_busy[0]}, 32'h1);
    step(3, 0, 2'b01, 3, 32'h55, 0, 0, 1'b0, 0);
    chk("wb_busy_masked", {31'd0, c_busy[0]}, 32'h0);
    chk("wb_byp", c_data[31:0], 32'h55);
    step(3, 0, 2'b00, 0, 0, 0, 0, 1'b0, 0);
    chk("wb_busy_cleared", {31'd0, c_busy[0]}, 32'h0);
    chk("wb_stored", c_data[31:0], 32'h55);
    step(3, 0, 2'b10, 0, 0, 3, 32'h66, 1'b1, 3);
    chk("iss_wb_byp", c_data[31:0], 32'h66);
    chk("iss_wb_busy_now", {31'd0, c_busy[0]}, 32'h0);
    step(3, 0, 2'b00, 0, 0, 0, 0, 1'b0, 0);
    chk("iss_wb_busy_after", {31'd0, c_busy[0]}, 32'h1);
    chk("iss_wb_data", c_data[31:0], 32'h66);
    step(4, 0, 2'b01, 4, 32'h44, 0, 0, 1'b0, 0);
    step(4, 0, 2'b00, 0, 0, 0, 0, 1'b0, 0);
    chk("idle_wb_busy", {31'd0, c_busy[0]}, 32'h0);
    chk("idle_wb_data", c_data[31:0], 32'h44);
    step(9, 0, 2'b01, 9, 32'hA5A5A5A5, 0, 0, 1'b0, 0);
    chk("rr_prev", r_data[31:0], 32'h44);
    step(5, 7, 2'b00, 0, 0, 0, 0, 1'b0, 0);
    chk("rr_r9", r_data[31:0], 32'hA5A5A5A5);
    step(7, 9, 2'b00, 0, 0, 0, 0, 1'b0, 0);
    chk("rr_pipe_p0_a", r_data[31:0], 32'hDEADBEEF);
    chk("rr_pipe_p1_a", r_data[63:32], 32'h22);
    step(29, 0, 2'b00, 0, 0, 0, 0, 1'b0, 0);
    chk("rr_pipe_p0_b", r_data[31:0], 32'h22);
    chk("rr_pipe_p1_b", r_data[63:32], 32'hA5A5A5A5);
    step(29, 0, 2'b01, 29, 32'h1234, 0, 0, 1'b0, 0);
    chk("rr_pipe_sp", r_data[31:0], 32'h000007fc);
    chk("sp_write_byp", c_data[31:0], 32'h1234);
    step(29, 0, 2'b00, 0, 0, 0, 0, 1'b0, 0);
    chk("sp_write_stored", c_data[31:0], 32'h1234);
    step(29, 0, 2'b01, 5, 32'hCAFE, 0, 0, 1'b1, 6);
    reset_n = 1'b0;
    #1;
    chk("midrst_reg_data", r_data[31:0], 32'h0);
    chk("midrst_sp", c_data[31:0], 32'h000007fc);
    step(0, 0, 2'b00, 0, 0, 0, 0, 1'b0, 0);
    reset_n = 1'b1;
    for (int a = 0; a < 32; a++) begin
      step(5'(a), 5'(31 - a), 2'b00, 0, 0, 0, 0, 1'b0, 0);
      chk($sformatf("rst_r%0d", a), c_data[31:0], (a == 29) ? 32'h000007fc : 32'h0);
      chk($sformatf("rst_r%0d_p1", 31 - a), c_data[63:32], (a == 2) ? 32'h000007fc : 32'h0);
      chk($sformatf("rst_busy%0d", a), {30'd0, c_busy}, 32'h0);
      if (a > 0) chk($sformatf("rst_rr%0d", a - 1), r_data[31:0], (a == 30) ? 32'h000007fc : 32'h0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
